heap_pq_seq: RTL and testbench
==============================

// Module: heap_pq_seq
// PURPOSE
//  Sequential binary max-heap priority queue. It is the responder side of the pq_if enq/deq/busy handshake.
//  Stores {key,val} entries in a register array with 1-based heap indexing.
//  kvo always presents the largest key. One heap level is sifted per clock.
//  It sits behind pq_if as a drop-in PQ implementation for the HWPQ study.
// PARAMETERS
//  KEY_WIDTH  8  key bits; the key is the upper field of kvi/kvo; a larger key means higher priority
//  VAL_WIDTH  8  value bits; the value is the lower field of kvi/kvo
//  DEPTH      7  entries held (heap slots 1..DEPTH); must be 2**n-1
// PORTS
//  clk    in   1                    clock, rising edge
//  rst    in   1                    asynchronous reset, active-low
//  enq    in   1                    enqueue request; 1-cycle pulse, sampled only when busy==0
//  deq    in   1                    dequeue request; 1-cycle pulse, sampled only when busy==0
//  kvi    in   KEY_WIDTH+VAL_WIDTH  {key,val} to enqueue
//  kvo    out  KEY_WIDTH+VAL_WIDTH  heap[1] (top entry); valid when empty==0 && busy==0
//  busy   out  1                    sift in progress; requests are ignored while it is high
//  full   out  1                    count==DEPTH
//  empty  out  1                    count==0
// BEHAVIOUR
//  Reset (rst low, async, any cycle including mid-sift):
//   - heap cleared to 0, count=0, state=IDLE
//   - kvo=0, busy=0, full=0, empty=1
//  FSM states: IDLE, SIFT_UP, SIFT_DOWN. busy=1 exactly when state!=IDLE. busy is registered.
//  IDLE, enq=1, deq=0, !full:
//   - heap[count+1]<=kvi; idx<=count+1; count++; ->SIFT_UP
//  IDLE, deq=1, enq=0, !empty:
//   - heap[1]<=heap[count]; heap[count]<=0; count--; idx<=1; ->SIFT_DOWN
//   - The dequeued item is kvo as seen during the request cycle.
//  IDLE, enq=1, deq=1, !empty (replace-top, count unchanged):
//   - heap[1]<=kvi; idx<=1; ->SIFT_DOWN; the old kvo is the dequeued item.
//   - This is legal when full.
//  IDLE, enq=1, deq=1, empty: treated as enq only.
//  Ignored requests (no state change):
//   - enq alone when full
//   - deq alone when empty
//   - any request while busy
//  SIFT_UP, one cycle per step:
//   - If idx==1 or key(heap[idx]) <= key(parent=idx>>1): ->IDLE.
//   - Otherwise swap heap[idx] with its parent, idx<=idx>>1.
//  SIFT_DOWN, one cycle per step:
//   - l=2*idx, r=2*idx+1.
//   - Pick the child with the larger key among those with index <= count; on a key tie pick l.
//   - If there is no child, or key(child) <= key(heap[idx]): ->IDLE.
//   - Otherwise swap heap[idx] with that child, idx<=child.
//  Latency:
//   - busy rises the cycle after the request edge.
//   - busy stays high for (swaps+1) cycles, at most log2(DEPTH+1) cycles.
//  Comparisons use the key field only, unsigned. Equal keys never swap, so ordering among equal keys is unspecified.
//  full and empty update with count on the accept edge.
//  kvo may show intermediate values while busy==1.
// CONFIGURATION
//  HEAP_PQ_SEQ_ERR_EN defined:
//   - Adds output err (1 bit), sticky and cleared only by rst.
//   - err is set on the edge after an ignored enq-when-full or deq-when-empty request.
//   - Requests ignored because busy==1 do not set err.
//  HEAP_PQ_SEQ_ERR_EN undefined: no err port; such requests are silently dropped.
// TESTING (KEY_WIDTH=8, VAL_WIDTH=8, DEPTH=7)
//  T1 reset, then enq keys 20,80,30,70,50,60,40 (vals 1..6,8), waiting for busy==0 each time
//     -> full=1, kvo=8002.
//  T2 from T1, enq+deq {90,08} -> dequeued kvo=8002; after busy drops kvo=9008, full=1 still.
//  T3 from T2, deq until empty -> kvo sequence 90,70,60,50,40,30,20; then empty=1, kvo=0000.
//  T4 from empty, enq increasing 20..80 (vals 1..7) -> 80 busy high 3 cycles (2 swaps); kvo=8007.
//     Then enq {10,01} while full -> ignored; kvo/full unchanged; err=1 if enabled.
//  T5 pulse rst low mid-SIFT_DOWN -> busy=0, empty=1, kvo=0 immediately (before next clk edge).

Source files
------------

// File: rtl/heap_pq_seq_if.sv
// Request/response bundle between a priority-queue requester and a PQ implementation.
// The optional err line is present only when HEAP_PQ_SEQ_ERR_EN is defined.
interface heap_pq_seq_if #(
  parameter int KEY_WIDTH = 8,
  parameter int VAL_WIDTH = 8
);
  logic                           enq;
  logic                           deq;
  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi;
  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo;
  logic                           busy;
  logic                           full;
  logic                           empty;
`ifdef HEAP_PQ_SEQ_ERR_EN
  logic                           err;
`endif

  modport master (
    output enq, deq, kvi,
    input  kvo, busy, full, empty
`ifdef HEAP_PQ_SEQ_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  enq, deq, kvi,
    output kvo, busy, full, empty
`ifdef HEAP_PQ_SEQ_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/heap_pq_seq.sv
// Sequential binary max-heap priority queue, one heap level sifted per clock.
// Heap slots are 1-based; slot 1 is always presented on kvo.
// Optional feature macro: HEAP_PQ_SEQ_ERR_EN adds a sticky err flag for
// enqueue-when-full / dequeue-when-empty requests.
//
// state     | meaning
// IDLE      | waiting for enq/deq, busy=0
// SIFT_UP   | new entry bubbling toward the root
// SIFT_DOWN | root entry sinking toward the leaves
module heap_pq_seq #(
  parameter int KEY_WIDTH = 8,
  parameter int VAL_WIDTH = 8,
  parameter int DEPTH     = 7
) (
  input logic          clk,
  input logic          rst_n,
  heap_pq_seq_if.slave pq
);
  localparam int W  = KEY_WIDTH + VAL_WIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = CW + 1;

  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

  state_t        state_q;
  logic [W-1:0]  heap_q [1:DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] idx_q;
  logic          busy_q;
  logic          err_q;

  logic [CW-1:0]        par_idx;
  logic [IW-1:0]        l_idx, r_idx;
  logic [CW-1:0]        child_idx;
  logic [KEY_WIDTH-1:0] cur_key, par_key, l_key, r_key, child_key;
  logic                 has_l, has_r, up_swap, down_swap;
  logic                 full_w, empty_w;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // Neighbour lookup and swap decisions for the current sift position
  always_comb begin
    par_idx   = idx_q >> 1;
    l_idx     = {1'b0, idx_q} << 1;
    r_idx     = l_idx | IW'(1);
    has_l     = (l_idx <= {1'b0, count_q});
    has_r     = (r_idx <= {1'b0, count_q});
    cur_key   = heap_q[idx_q][W-1 -: KEY_WIDTH];
    par_key   = heap_q[par_idx][W-1 -: KEY_WIDTH];
    l_key     = has_l ? heap_q[l_idx[CW-1:0]][W-1 -: KEY_WIDTH] : '0;
    r_key     = has_r ? heap_q[r_idx[CW-1:0]][W-1 -: KEY_WIDTH] : '0;
    // left child wins ties
    if (has_r && (r_key > l_key)) begin
      child_idx = r_idx[CW-1:0];
      child_key = r_key;
    end else begin
      child_idx = l_idx[CW-1:0];
      child_key = l_key;
    end
    up_swap   = (idx_q != CW'(1)) && (cur_key > par_key);
    down_swap = has_l && (child_key > cur_key);
  end

  // Request acceptance, heap storage updates and sift stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 1; i <= DEPTH; i++) heap_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pq.enq && pq.deq && !empty_w) begin
            heap_q[1] <= pq.kvi;
            idx_q     <= CW'(1);
            state_q   <= SIFT_DOWN;
            busy_q    <= 1'b1;
          end else if (pq.enq && !full_w) begin
            heap_q[count_q + CW'(1)] <= pq.kvi;
            idx_q   <= count_q + CW'(1);
            count_q <= count_q + CW'(1);
            state_q <= SIFT_UP;
            busy_q  <= 1'b1;
          end else if (pq.deq && !pq.enq && !empty_w) begin
            // when count==1 the second write clears slot 1
            heap_q[1]       <= heap_q[count_q];
            heap_q[count_q] <= '0;
            count_q <= count_q - CW'(1);
            idx_q   <= CW'(1);
            state_q <= SIFT_DOWN;
            busy_q  <= 1'b1;
          end else if ((pq.enq && !pq.deq && full_w) || (pq.deq && !pq.enq && empty_w)) begin
            err_q <= 1'b1;
          end
        end
        SIFT_UP: begin
          if (up_swap) begin
            heap_q[idx_q]   <= heap_q[par_idx];
            heap_q[par_idx] <= heap_q[idx_q];
            idx_q           <= par_idx;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SIFT_DOWN: begin
          if (down_swap) begin
            heap_q[idx_q]     <= heap_q[child_idx];
            heap_q[child_idx] <= heap_q[idx_q];
            idx_q             <= child_idx;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pq.kvo   = heap_q[1];
  assign pq.busy  = busy_q;
  assign pq.full  = full_w;
  assign pq.empty = empty_w;
`ifdef HEAP_PQ_SEQ_ERR_EN
  assign pq.err   = err_q;
`else
  logic err_unused;
  assign err_unused = err_q;
`endif
endmodule

// File: tb/tb_heap_pq_seq.sv
// Self-checking bench for heap_pq_seq: directed scenarios then randomized
// traffic compared against a multiset reference model of the queue contents.
module tb_heap_pq_seq;
  localparam int DEPTH = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   exp_err = 1'b0;
  logic [15:0] mdl [$];

  always #5 clk = ~clk;

  heap_pq_seq_if #(.KEY_WIDTH(8), .VAL_WIDTH(8)) pq_bus ();

  heap_pq_seq #(.KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pq   (pq_bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mdl_max_key();
    logic [7:0] m = 8'h00;
    foreach (mdl[i]) if (mdl[i][15:8] > m) m = mdl[i][15:8];
    return m;
  endfunction

  function automatic int mdl_find(input logic [15:0] kv);
    foreach (mdl[i]) if (mdl[i] === kv) return i;
    return -1;
  endfunction

  task automatic post_check();
    chk("full", pq_bus.full, (mdl.size() == DEPTH));
    chk("empty", pq_bus.empty, (mdl.size() == 0));
    if (mdl.size() > 0) begin
      chk("top_key", pq_bus.kvo[15:8], mdl_max_key());
      chk("top_in_model", (mdl_find(pq_bus.kvo) >= 0), 1);
    end else begin
      chk("top_empty", pq_bus.kvo, 0);
    end
`ifdef HEAP_PQ_SEQ_ERR_EN
    chk("err", pq_bus.err, exp_err);
`endif
  endtask

  // One request pulse; optionally pokes a stray enq while the sift runs.
  task automatic do_req(input logic e, input logic d, input logic [15:0] kv, input bit poke,
                        output logic [15:0] top, output int bcyc);
    @(negedge clk);
    top = pq_bus.kvo;
    pq_bus.enq = e;
    pq_bus.deq = d;
    pq_bus.kvi = kv;
    @(negedge clk);
    pq_bus.enq = 1'b0;
    pq_bus.deq = 1'b0;
    bcyc = 0;
    if (pq_bus.busy && poke) begin
      pq_bus.enq = 1'b1;
      pq_bus.kvi = 16'($urandom);
    end
    while (pq_bus.busy && bcyc < 20) begin
      bcyc++;
      @(negedge clk);
      pq_bus.enq = 1'b0;
    end
    if (bcyc >= 20) chk("busy_timeout", bcyc, 0);
  endtask

  task automatic op(input logic e, input logic d, input logic [15:0] kv, input bit poke,
                    output logic [15:0] top, output int bcyc);
    int sz;
    bit repl, ins, rem;
    int fi;
    sz   = mdl.size();
    repl = e && d && sz > 0;
    ins  = !repl && e && sz < DEPTH;
    rem  = !repl && !ins && d && !e && sz > 0;
    do_req(e, d, kv, poke, top, bcyc);
    if (repl || ins || rem) begin
      chk("busy_len", (bcyc >= 1 && bcyc <= 3), 1);
    end else begin
      chk("ignored_no_busy", bcyc, 0);
      exp_err = 1'b1;
    end
    if (repl || rem) begin
      chk("deq_key", top[15:8], mdl_max_key());
      fi = mdl_find(top);
      chk("deq_in_model", (fi >= 0), 1);
      if (fi >= 0) mdl.delete(fi);
    end
    if (repl || ins) mdl.push_back(kv);
    post_check();
  endtask

  logic [15:0] top;
  int          bc;
  logic [7:0]  t1k [7] = '{8'h20, 8'h80, 8'h30, 8'h70, 8'h50, 8'h60, 8'h40};
  logic [7:0]  t1v [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08};
  logic [15:0] t3e [7] = '{16'h9008, 16'h7004, 16'h6006, 16'h5005, 16'h4008, 16'h3003, 16'h2001};

  initial begin
    pq_bus.enq = 1'b0;
    pq_bus.deq = 1'b0;
    pq_bus.kvi = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", pq_bus.busy, 0);
    chk("rst_empty", pq_bus.empty, 1);
    chk("rst_full", pq_bus.full, 0);
    chk("rst_kvo", pq_bus.kvo, 0);
    rst_n = 1'b1;

    // T1
    for (int i = 0; i < 7; i++) op(1'b1, 1'b0, {t1k[i], t1v[i]}, 1'b0, top, bc);
    chk("t1_full", pq_bus.full, 1);
    chk("t1_kvo", pq_bus.kvo, 16'h8002);

    // T2 replace-top while full
    op(1'b1, 1'b1, 16'h9008, 1'b0, top, bc);
    chk("t2_deq", top, 16'h8002);
    chk("t2_kvo", pq_bus.kvo, 16'h9008);
    chk("t2_full", pq_bus.full, 1);

    // T3 drain
    for (int i = 0; i < 7; i++) begin
      op(1'b0, 1'b1, 16'h0000, 1'b0, top, bc);
      chk("t3_deq", top, t3e[i]);
    end
    chk("t3_empty", pq_bus.empty, 1);
    chk("t3_kvo", pq_bus.kvo, 0);

    // T4 increasing keys, then enq while full
    for (int i = 0; i < 7; i++) begin
      op(1'b1, 1'b0, {8'h20 + 8'(i * 16), 8'(i + 1)}, 1'b0, top, bc);
      if (i == 6) chk("t4_busy_cycles", bc, 3);
    end
    chk("t4_kvo", pq_bus.kvo, 16'h8007);
    op(1'b1, 1'b0, 16'h1001, 1'b0, top, bc);
    chk("t4_ign_kvo", pq_bus.kvo, 16'h8007);
    chk("t4_ign_full", pq_bus.full, 1);
`ifdef HEAP_PQ_SEQ_ERR_EN
    chk("t4_err", pq_bus.err, 1);
`endif

    // T5 async reset in the middle of a sift-down
    @(negedge clk);
    pq_bus.deq = 1'b1;
    @(negedge clk);
    pq_bus.deq = 1'b0;
    chk("t5_busy_before", pq_bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", pq_bus.busy, 0);
    chk("t5_empty", pq_bus.empty, 1);
    chk("t5_kvo", pq_bus.kvo, 0);
`ifdef HEAP_PQ_SEQ_ERR_EN
    chk("t5_err", pq_bus.err, 0);
`endif
    mdl.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic e, d;
      logic [15:0] kv;
      sel = $urandom_range(0, 9);
      e   = (sel <= 4) || (sel >= 8);
      d   = (sel >= 5);
      kv  = {8'($urandom_range(0, 31)), 8'($urandom)};
      op(e, d, kv, ($urandom_range(0, 3) == 0), top, bc);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
